// File: rtl/wb_test_master_core_if.sv
// wb_test_master_core_if: command/response channel plus Wishbone classic bus of wb_test_master_core.
interface wb_test_master_core_if #(parameter int g_addr_width = 32);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [1:0]              cmd_op;
   logic [g_addr_width-1:0] cmd_addr;
   logic [31:0]             cmd_data;
   logic [3:0]              cmd_sel;
   logic                    rsp_valid;
   logic [31:0]             rsp_data;
   logic                    rsp_err;
   logic                    wb_cyc;
   logic                    wb_stb;
   logic                    wb_we;
   logic [3:0]              wb_sel;
   logic [g_addr_width-1:0] wb_adr;
   logic [31:0]             wb_wdat;
   logic [31:0]             wb_rdat;
   logic                    wb_ack;
   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_sel, wb_rdat, wb_ack,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_wdat
   );
   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_sel, wb_rdat, wb_ack,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_wdat
   );
endinterface

// File: rtl/wb_test_master_core.sv
// wb_test_master_core: single-outstanding Wishbone classic master for read, write and poll-until-set.
// Defining WB_TM_MONITOR_EN adds mon_count_o / mon_last_adr_o (completed-cycle monitor).
module wb_test_master_core #(
   parameter int g_addr_width = 32,
   parameter int g_timeout    = 1023,
   parameter int g_max_poll   = 65535
) (
   input logic clk_i,
   input logic rst_n_i,
   wb_test_master_core_if.master bus
`ifdef WB_TM_MONITOR_EN
   ,
   output logic [15:0]             mon_count_o,
   output logic [g_addr_width-1:0] mon_last_adr_o
`endif
);
   localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, GAP = 2'd2, RESP = 2'd3;
   localparam logic [1:0] OP_WR = 2'd1, OP_POLL = 2'd2, OP_RSV = 2'd3;
   localparam logic [15:0] TMO_LAST  = 16'(g_timeout - 1);
   localparam logic [15:0] POLL_LAST = 16'(g_max_poll - 1);

   logic [1:0]              state, op;
   logic [31:0]             mask, rsp_data, wdat;
   logic [g_addr_width-1:0] adr;
   logic [3:0]              sel;
   logic [15:0]             tmo_cnt, poll_cnt;
   logic                    cmd_ready, rsp_err, cyc, we;
   logic                    done, hit, again;

   // done: the current bus cycle ends this edge, by ack or by timeout (ack wins a tie)
   assign done  = state == BUS && (bus.wb_ack || tmo_cnt == TMO_LAST);
   assign hit   = (bus.wb_rdat & mask) != '0;
   assign again = bus.wb_ack && op == OP_POLL && !hit && poll_cnt != POLL_LAST;

   assign bus.cmd_ready = cmd_ready;
   assign bus.rsp_valid = state == RESP;
   assign bus.rsp_data  = rsp_data;
   assign bus.rsp_err   = rsp_err;
   assign bus.wb_cyc    = cyc;
   assign bus.wb_stb    = cyc;
   assign bus.wb_we     = we;
   assign bus.wb_sel    = sel;
   assign bus.wb_adr    = adr;
   assign bus.wb_wdat   = wdat;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state     <= IDLE;
         op        <= '0;
         mask      <= '0;
         rsp_data  <= '0;
         wdat      <= '0;
         adr       <= '0;
         sel       <= '0;
         tmo_cnt   <= '0;
         poll_cnt  <= '0;
         cmd_ready <= 1'b0;
         rsp_err   <= 1'b0;
         cyc       <= 1'b0;
         we        <= 1'b0;
      end else
         case (state)
            IDLE:
               if (cmd_ready && bus.cmd_valid) begin
                  cmd_ready <= 1'b0;
                  op        <= bus.cmd_op;
                  mask      <= bus.cmd_data;
                  adr       <= bus.cmd_addr;
                  sel       <= bus.cmd_sel;
                  tmo_cnt   <= '0;
                  poll_cnt  <= '0;
                  rsp_data  <= '0;
                  rsp_err   <= bus.cmd_op == OP_RSV;
                  cyc       <= bus.cmd_op != OP_RSV;
                  we        <= bus.cmd_op == OP_WR;
                  wdat      <= bus.cmd_op == OP_WR ? bus.cmd_data : '0;
                  state     <= bus.cmd_op == OP_RSV ? RESP : BUS;
               end else
                  cmd_ready <= 1'b1;
            BUS:
               if (done) begin
                  cyc      <= 1'b0;
                  we       <= 1'b0;
                  wdat     <= '0;
                  tmo_cnt  <= '0;
                  rsp_data <= bus.wb_ack && op != OP_WR ? bus.wb_rdat : '0;
                  rsp_err  <= !bus.wb_ack || (op == OP_POLL && !hit && poll_cnt == POLL_LAST);
                  poll_cnt <= again ? poll_cnt + 16'd1 : poll_cnt;
                  state    <= again ? GAP : RESP;
               end else
                  tmo_cnt <= tmo_cnt + 16'd1;
            GAP: begin
               cyc   <= 1'b1;
               state <= BUS;
            end
            default: begin
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase

`ifdef WB_TM_MONITOR_EN
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         mon_count_o    <= '0;
         mon_last_adr_o <= '0;
      end else if (done) begin
         mon_count_o    <= mon_count_o + 16'd1;
         mon_last_adr_o <= adr;
      end
`endif
endmodule

// File: tb/tb_wb_test_master_core.sv
// tb_wb_test_master_core: randomized command stream against a transaction-level model of the master.
// Built with g_timeout=16, g_max_poll=4; monitor outputs checked when WB_TM_MONITOR_EN is defined.
module tb_wb_test_master_core;
   localparam int TMO  = 16;
   localparam int MAXP = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   int          s_waits[$], sl_waits[$];
   logic [31:0] s_data[$], sl_data[$];
   bit          in_cyc = 1'b0;
   int          cur_w = 0;
   logic [31:0] cur_d = '0;
   logic [15:0] exp_mc = '0;
   logic [31:0] exp_la = '0;

   wb_test_master_core_if #(.g_addr_width(32)) bus ();

`ifdef WB_TM_MONITOR_EN
   logic [15:0] mon_count;
   logic [31:0] mon_last_adr;
`endif

   wb_test_master_core #(.g_addr_width(32), .g_timeout(TMO), .g_max_poll(MAXP)) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .bus(bus)
`ifdef WB_TM_MONITOR_EN
      ,
      .mon_count_o(mon_count),
      .mon_last_adr_o(mon_last_adr)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int w, input logic [31:0] d);
      s_waits.push_back(w);
      s_data.push_back(d);
   endtask

   // Slave: each new bus cycle takes (wait states, data) from the script; stray acks when idle
   initial begin
      bus.wb_ack  = 1'b0;
      bus.wb_rdat = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.wb_cyc && bus.wb_stb) begin
            if (!in_cyc) begin
               in_cyc = 1'b1;
               cur_w  = sl_waits.size() > 0 ? sl_waits.pop_front() : 1000;
               cur_d  = sl_data.size() > 0 ? sl_data.pop_front() : 32'h0;
            end
            bus.wb_ack  = cur_w == 0;
            bus.wb_rdat = cur_w == 0 ? cur_d : $urandom;
            if (cur_w > 0) cur_w--;
         end else begin
            in_cyc      = 1'b0;
            bus.wb_ack  = $urandom_range(0, 3) == 0;
            bus.wb_rdat = $urandom;
         end
      end
   end

   // Transaction model: response, cycles from acceptance to rsp_valid, stb cycles, completed bus cycles
   task automatic model(input logic [1:0] op, input logic [31:0] mask, output logic [31:0] d,
                        output bit e, output int lat, output int stb, output int nbus);
      d = '0; e = 1'b0; lat = 0; stb = 0; nbus = 0;
      if (op == 2'd3) begin
         e = 1'b1;
         lat = 1;
         return;
      end
      for (int i = 0; i < (op == 2'd2 ? MAXP : 1); i++) begin
         if (i > 0) lat++;
         nbus++;
         if (s_waits[i] >= TMO) begin
            stb += TMO; lat += TMO; e = 1'b1; d = '0;
            break;
         end
         stb += s_waits[i] + 1;
         lat += s_waits[i] + 1;
         if (op == 2'd1) break;
         d = s_data[i];
         if (op == 2'd0 || (d & mask) != 0) break;
         if (i == MAXP - 1) e = 1'b1;
      end
      lat++;
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 50 && !bus.cmd_ready; n++) begin
         @(posedge clk);
         #1;
      end
      check("cmd_ready_idle", bus.cmd_ready, 1);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel);
      logic [31:0] ed, gd;
      bit          ee, ge;
      int          el, es, eb, gl, gs, bad;
      model(op, data, ed, ee, el, es, eb);
      sl_waits = s_waits;
      sl_data  = s_data;
      s_waits.delete();
      s_data.delete();
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = addr;
      bus.cmd_data  = data;
      bus.cmd_sel   = sel;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_addr  = $urandom;
      bus.cmd_data  = $urandom;
      bus.cmd_sel   = 4'($urandom);
      gl = 0; gs = 0; bad = 0; gd = 'x; ge = 1'bx;
      for (int k = 1; k <= 200; k++) begin
         if (bus.cmd_ready) bad++;
         if (bus.wb_stb) begin
            gs++;
            if (!bus.wb_cyc || bus.wb_we !== (op == 2'd1) || bus.wb_wdat !== (op == 2'd1 ? data : 32'h0) ||
                bus.wb_adr !== addr || bus.wb_sel !== sel) bad++;
         end else if (bus.wb_cyc || bus.wb_we || bus.wb_wdat != 0) bad++;
         if (bus.rsp_valid) begin
            gl = k; gd = bus.rsp_data; ge = bus.rsp_err;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("rsp_latency", gl, el);
      check("stb_cycles", gs, es);
      check("rsp_data", gd, ed);
      check("rsp_err", ge, ee);
      check("bus_fields", bad, 0);
      @(posedge clk);
      #1;
      check("post_rsp_valid_ready", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
      if (op != 2'd3) check("adr_sel_hold", {bus.wb_adr, bus.wb_sel}, {addr, sel});
`ifdef WB_TM_MONITOR_EN
      exp_mc += 16'(eb);
      if (eb > 0) exp_la = addr;
      check("mon_count", mon_count, exp_mc);
      check("mon_last_adr", mon_last_adr, exp_la);
`endif
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] mask, d;
      logic        seen;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_addr  = '0;
      bus.cmd_data  = '0;
      bus.cmd_sel   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.wb_cyc, bus.wb_stb, bus.wb_we}, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_wdat", bus.wb_wdat, 0);
      check("rst_adr_sel", {bus.wb_adr, bus.wb_sel}, 0);
      rst_n = 1'b1;
      check("ready_before_first_edge", bus.cmd_ready, 0);
      @(posedge clk);
      #1;
      check("ready_after_release", bus.cmd_ready, 1);

      push(2, 32'h0);
      run_cmd(2'd1, 32'h08, 32'h0000AABB, 4'hF);
      push(0, 32'hCCDDEEFF);
      run_cmd(2'd0, 32'h0C, 32'h0, 4'hF);
      push(0, 32'h0); push(0, 32'h0); push(0, 32'h00010001); push(0, 32'h0);
      run_cmd(2'd2, 32'h20, 32'h00000001, 4'hF);
      push(100, 32'h12345678);
      run_cmd(2'd0, 32'h30, 32'h0, 4'h3);
      push(15, 32'h0BADF00D);
      run_cmd(2'd0, 32'h34, 32'h0, 4'hC);
      push(16, 32'h0BADF00D);
      run_cmd(2'd0, 32'h38, 32'h0, 4'h1);
      push(0, 32'h7); push(1, 32'h7); push(0, 32'h7); push(2, 32'h7);
      run_cmd(2'd2, 32'h44, 32'h00000008, 4'hF);
      run_cmd(2'd3, 32'h50, 32'hFFFFFFFF, 4'hF);

      for (int t = 0; t < 40; t++) begin
         op   = 2'($urandom_range(0, 3));
         mask = 32'h1 << $urandom_range(0, 31);
         for (int i = 0; i < (op == 2'd2 ? MAXP : 1); i++) begin
            d = $urandom & ~mask;
            if ($urandom_range(0, 2) == 0) d = d | mask;
            push($urandom_range(0, 9) == 0 ? 20 : $urandom_range(0, 4), d);
         end
         run_cmd(op, $urandom, op == 2'd2 ? mask : $urandom, 4'($urandom));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      push(10, 32'h55550000);
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd0;
      bus.cmd_addr  = 32'h40;
      bus.cmd_sel   = 4'hF;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("stb_before_reset", bus.wb_stb, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_drop_cyc_stb", {bus.wb_cyc, bus.wb_stb}, 0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         seen = seen | bus.rsp_valid | bus.cmd_ready | bus.wb_cyc;
      end
      check("quiet_in_reset", seen, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_mid_reset", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
      exp_mc = '0;
      exp_la = '0;
`ifdef WB_TM_MONITOR_EN
      check("mon_count_reset", mon_count, 0);
`endif
      push(0, 32'h11111111);
      run_cmd(2'd0, 32'h100, 32'h0, 4'hF);
      push(3, 32'h0);
      run_cmd(2'd1, 32'h104, 32'hDEADBEEF, 4'h5);
      push(1, 32'h33333333);
      run_cmd(2'd0, 32'h108, 32'h0, 4'hA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
